room_input_debounce: RTL and testbench
======================================

Name: room_input_debounce

Overview:
- Front-end conditioning stage for the room-management system.
- Synchronises and debounces 12 raw room switch/sensor inputs, then drives the stable level inputs (case1..case12) of the downstream reset-pulse generator.
- Guarantees the downstream stage sees only clean, glitch-free level changes, so bounce cannot trigger a burst of display resets.
- Also reports which rooms changed in each cycle.

Parameters:
- N_CH, 12: number of room input channels.
- TICK_DIV, 50000: iCLK cycles per debounce tick (1 ms at 50 MHz); must be >= 2.
- DB_TICKS, 10: consecutive ticks an input must hold a new value before it is accepted; must be >= 1.
- CNT_W, $clog2(TICK_DIV): width of the prescaler counter.

Ports:
- iCLK  in  1  system clock.
- iRST  in  1  synchronous, active-high reset.
- iSW  in  N_CH  raw asynchronous room inputs (switches/sensors).
- oCASE  out  N_CH  debounced stable levels; bit k feeds case(k+1) downstream.
- oCHANGE  out  1  one-cycle pulse when any oCASE bit changes in that cycle.
- oCHANGE_MASK  out  N_CH  bit k high for one cycle when oCASE[k] changes.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high: iRST sampled high at a rising edge of iCLK resets everything.
  - Reset values: oCASE=0, oCHANGE=0, oCHANGE_MASK=0, sync flops=0, prescaler=0, all channels IDLE with count 0.
  - oCASE resets to 0 to match the downstream power-up state, so no spurious change is reported after reset.
  - Reset mid-qualification aborts it with no commit.
- Synchroniser: two flip-flops per channel, giving s[k] two edges after iSW is sampled.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for exactly the cycle in which the count equals TICK_DIV-1.
  - Shared by all channels; free-running and never restarted by a channel event.
- Per-channel FSM, states IDLE and QUAL, with a tick counter of width $clog2(DB_TICKS+1):
  - IDLE: if s[k]!=oCASE[k], go to QUAL and clear count to 0. Otherwise stay.
  - QUAL, s[k]==oCASE[k] (bounce back): go to IDLE, count=0, no output change.
  - QUAL, s[k]!=oCASE[k] with tick and count==DB_TICKS-1: commit. oCASE[k]<=s[k], oCHANGE_MASK[k]<=1, go to IDLE.
  - QUAL, s[k]!=oCASE[k] with tick otherwise: count++.
  - A tick in the same cycle as the IDLE->QUAL entry is not counted.
- Latency:
  - The commit occurs on the DB_TICKS-th tick after QUAL entry.
  - From the edge that first samples a new iSW value to the oCASE update: 3+1+(DB_TICKS-1)*TICK_DIV to 3+DB_TICKS*TICK_DIV cycles.
- Outputs:
  - oCASE, oCHANGE_MASK and oCHANGE are all registered and update on the same edge.
  - oCHANGE = OR of the next oCHANGE_MASK.
  - Mask bits are single-cycle pulses.
- Simultaneous events:
  - Several channels may commit in the same cycle; all of their mask bits are set together and oCHANGE pulses once.
  - Channels are fully independent.
- Pulses shorter than DB_TICKS ticks never reach oCASE.

Optional Feature:
- Macro: ROOM_DEBOUNCE_STICKY_EN.
- When defined:
  - Adds input iCLR_STICKY (1 bit) and output oSTICKY (N_CH bits).
  - oSTICKY[k] is set on any commit of channel k and held until iCLR_STICKY is high at a clock edge.
  - Set wins over clear in the same cycle.
  - Reset value is 0.
- When undefined: these ports and registers do not exist, and all other behaviour is identical.

Decomposition:
- Package room_pkg:
  - N_ROOMS=12.
  - Enum db_state_t {DB_IDLE, DB_QUAL}.
  - Default TICK_DIV/DB_TICKS constants.
- Sub-module room_debounce_ch:
  - One channel: sync flops, FSM, tick counter, commit pulse.
  - Instantiated N_CH times by generate.
- The top level holds the shared prescaler, the output registers and the optional sticky logic.

Test Plan:
- All tests use TICK_DIV=4, DB_TICKS=3.
- Reset, then hold iSW=0 for 100 cycles -> oCASE=0, oCHANGE never asserts.
- iSW[3] 0->1 and held -> oCASE[3]=1 between 12 and 15 cycles after the first sampling edge; oCHANGE_MASK=12'h008 and oCHANGE=1 for exactly one cycle.
- iSW[5] glitches high for 6 cycles, then returns to 0 -> oCASE[5] stays 0, no oCHANGE.
- iSW[0] and iSW[11] rise on the same edge -> both commit on the same cycle, oCHANGE_MASK=12'h801, single oCHANGE pulse.
- iSW[7] rises; iRST is asserted for 1 cycle after 2 ticks, then released with iSW[7] still 1 -> no commit before reset; after release, a full new qualification runs and oCASE[7]=1.
- With ROOM_DEBOUNCE_STICKY_EN: commit on channel 2 -> oSTICKY=12'h004 held. Raise iCLR_STICKY in the same cycle as a commit on channel 4 -> oSTICKY becomes 12'h010.

Source files
------------

// File: rtl/room_pkg.sv
// Shared constants and types for the room input debouncer.
package room_pkg;

  localparam int unsigned N_ROOMS      = 12;
  localparam int unsigned TICK_DIV_DEF = 50000;
  localparam int unsigned DB_TICKS_DEF = 10;

  typedef enum logic [0:0] {
    DB_IDLE = 1'b0,
    DB_QUAL = 1'b1
  } db_state_t;

endpackage

// File: rtl/room_debounce_ch.sv
// One debounce channel: two-flop synchroniser, IDLE/QUAL qualifier and tick counter.
// commit_c pulses in the cycle the synchronised input has differed from level for DB_TICKS ticks.
module room_debounce_ch
  import room_pkg::*;
#(
  parameter int unsigned DB_TICKS = DB_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  input  logic tick,
  input  logic level,
  output logic commit_c
);

  localparam int unsigned TC_W = $clog2(DB_TICKS + 1);

  logic [1:0]      sync_q;
  logic            s;
  db_state_t       state;
  db_state_t       state_nxt;
  logic [TC_W-1:0] count;
  logic [TC_W-1:0] count_nxt;

  assign s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      state  <= DB_IDLE;
      count  <= '0;
    end else begin
      sync_q <= {sync_q[0], sw};
      state  <= state_nxt;
      count  <= count_nxt;
    end
  end

  // A tick coinciding with QUAL entry is ignored because entry happens from IDLE.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    commit_c  = 1'b0;
    case (state)
      DB_IDLE: begin
        if (s != level) begin
          state_nxt = DB_QUAL;
          count_nxt = '0;
        end
      end
      DB_QUAL: begin
        if (s == level) begin
          state_nxt = DB_IDLE;
          count_nxt = '0;
        end else if (tick) begin
          if (count == TC_W'(DB_TICKS - 1)) begin
            commit_c  = 1'b1;
            state_nxt = DB_IDLE;
            count_nxt = '0;
          end else begin
            count_nxt = count + TC_W'(1);
          end
        end
      end
      default: begin
        state_nxt = DB_IDLE;
        count_nxt = '0;
      end
    endcase
  end

endmodule

// File: rtl/room_input_debounce.sv
// Debounces N_CH raw room inputs into clean levels with per-channel change pulses.
// Optional sticky change flags are built when ROOM_DEBOUNCE_STICKY_EN is defined.
module room_input_debounce
  import room_pkg::*;
#(
  parameter int unsigned N_CH     = N_ROOMS,
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned DB_TICKS = DB_TICKS_DEF,
  parameter int unsigned CNT_W    = $clog2(TICK_DIV)
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [N_CH-1:0] iSW,
  output logic [N_CH-1:0] oCASE,
  output logic            oCHANGE,
  output logic [N_CH-1:0] oCHANGE_MASK
`ifdef ROOM_DEBOUNCE_STICKY_EN
  ,
  input  logic            iCLR_STICKY,
  output logic [N_CH-1:0] oSTICKY
`endif
);

  logic [CNT_W-1:0] pre_cnt;
  logic             tick_c;
  logic [N_CH-1:0]  commit_c;

  assign tick_c = (pre_cnt == CNT_W'(TICK_DIV - 1));

  // Free-running prescaler shared by all channels.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pre_cnt <= '0;
    end else if (tick_c) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    room_debounce_ch #(
      .DB_TICKS(DB_TICKS)
    ) u_ch (
      .clk     (iCLK),
      .rst     (iRST),
      .sw      (iSW[k]),
      .tick    (tick_c),
      .level   (oCASE[k]),
      .commit_c(commit_c[k])
    );
  end

  // A commit always means the synchronised input differs from the level, so it flips the bit.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oCASE        <= '0;
      oCHANGE_MASK <= '0;
      oCHANGE      <= 1'b0;
    end else begin
      oCASE        <= oCASE ^ commit_c;
      oCHANGE_MASK <= commit_c;
      oCHANGE      <= |commit_c;
    end
  end

`ifdef ROOM_DEBOUNCE_STICKY_EN
  // Set has priority over clear.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oSTICKY <= '0;
    end else begin
      oSTICKY <= commit_c | (iCLR_STICKY ? '0 : oSTICKY);
    end
  end
`endif

endmodule

// File: tb/tb_room_input_debounce.sv
// Bench for room_input_debounce: segment table, hand-written latency/reset sequences and random traffic vs. a reference model.
module tb_room_input_debounce;

  localparam int unsigned NC = 12;
  localparam int TD = 4;
  localparam int DB = 3;

  logic          iCLK;
  logic          iRST;
  logic [NC-1:0] iSW;
  logic          iCLR_STICKY;
  logic [NC-1:0] oCASE;
  logic          oCHANGE;
  logic [NC-1:0] oCHANGE_MASK;
`ifdef ROOM_DEBOUNCE_STICKY_EN
  logic [NC-1:0] oSTICKY;
`endif

  room_input_debounce #(
    .N_CH    (NC),
    .TICK_DIV(TD),
    .DB_TICKS(DB)
  ) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iSW         (iSW),
    .oCASE       (oCASE),
    .oCHANGE     (oCHANGE),
    .oCHANGE_MASK(oCHANGE_MASK)
`ifdef ROOM_DEBOUNCE_STICKY_EN
    ,
    .iCLR_STICKY (iCLR_STICKY),
    .oSTICKY     (oSTICKY)
`endif
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: edge index since reset, two-edge input history, QUAL entry edge per channel.
  int            m_n;
  logic [NC-1:0] m_h1, m_h2;
  logic [NC-1:0] m_level, m_mask, m_sticky;
  logic          m_change;
  int            m_qs [NC];

  task automatic model_edge(input logic [NC-1:0] sw, input logic rst, input logic clr);
    logic [NC-1:0] s;
    logic [NC-1:0] commit;
    if (rst) begin
      m_n = 0; m_h1 = '0; m_h2 = '0;
      m_level = '0; m_mask = '0; m_change = 1'b0; m_sticky = '0;
      for (int k = 0; k < NC; k++) m_qs[k] = -1;
    end else begin
      m_n++;
      s = m_h2;
      m_h2 = m_h1;
      m_h1 = sw;
      commit = '0;
      for (int k = 0; k < NC; k++) begin
        if (m_qs[k] < 0) begin
          if (s[k] != m_level[k]) m_qs[k] = m_n;
        end else if (s[k] == m_level[k]) begin
          m_qs[k] = -1;
        end else if ((m_n % TD == 0) && ((m_n / TD) - (m_qs[k] / TD) == DB)) begin
          commit[k] = 1'b1;
          m_qs[k] = -1;
        end
      end
      m_level  = m_level ^ commit;
      m_mask   = commit;
      m_change = |commit;
      m_sticky = commit | (clr ? '0 : m_sticky);
    end
  endtask

  task automatic chk(input string name, input logic [NC-1:0] act, input logic [NC-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %03h expected %03h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [NC-1:0] sw, input logic rst, input logic clr);
    iSW = sw; iRST = rst; iCLR_STICKY = clr;
    @(posedge iCLK);
    model_edge(sw, rst, clr);
    #1;
    chk("model_case", oCASE, m_level);
    chk("model_mask", oCHANGE_MASK, m_mask);
    chk("model_change", NC'(oCHANGE), NC'(m_change));
`ifdef ROOM_DEBOUNCE_STICKY_EN
    chk("model_sticky", oSTICKY, m_sticky);
`endif
  endtask

  task automatic hold(input logic [NC-1:0] sw, input int cycles);
    for (int i = 0; i < cycles; i++) step(sw, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [NC-1:0] sw;
    int            cycles;
    logic [NC-1:0] exp_case;
    int            exp_chg;
    logic [NC-1:0] exp_mask;
  } seg_t;

  seg_t          segs [11];
  int            chg;
  logic [NC-1:0] mor;
  logic [NC-1:0] cur;
  logic [NC-1:0] flip;
  int            len;

  initial begin
    segs[0]  = '{12'h000, 100, 12'h000, 0, 12'h000};
    segs[1]  = '{12'h008,  16, 12'h008, 1, 12'h008};
    segs[2]  = '{12'h028,   6, 12'h008, 0, 12'h000};
    segs[3]  = '{12'h008,  20, 12'h008, 0, 12'h000};
    segs[4]  = '{12'h809,  16, 12'h809, 1, 12'h801};
    segs[5]  = '{12'h000,  16, 12'h000, 1, 12'h809};
    segs[6]  = '{12'hFFF,   5, 12'h000, 0, 12'h000};
    segs[7]  = '{12'h000,  10, 12'h000, 0, 12'h000};
    segs[8]  = '{12'h0F0,  16, 12'h0F0, 1, 12'h0F0};
    segs[9]  = '{12'h0E0,   3, 12'h0F0, 0, 12'h000};
    segs[10] = '{12'h0F0,  16, 12'h0F0, 0, 12'h000};

    iSW = '0; iRST = 1'b1; iCLR_STICKY = 1'b0;
    step('0, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    chk("reset_case", oCASE, 12'h000);
    chk("reset_mask", oCHANGE_MASK, 12'h000);

    for (int i = 0; i < 11; i++) begin
      chg = 0; mor = '0;
      for (int c = 0; c < segs[i].cycles; c++) begin
        step(segs[i].sw, 1'b0, 1'b0);
        if (oCHANGE) chg++;
        mor |= oCHANGE_MASK;
      end
      chk("seg_case", oCASE, segs[i].exp_case);
      chk("seg_changes", NC'(chg), NC'(segs[i].exp_chg));
      chk("seg_mask", mor, segs[i].exp_mask);
    end

    // Best-case latency: first sampling edge is edge 1, commit lands on edge 12.
    step('0, 1'b1, 1'b0);
    hold(12'h008, 11);
    chk("lat_min_before", oCASE, 12'h000);
    hold(12'h008, 1);
    chk("lat_min_case", oCASE, 12'h008);
    chk("lat_min_mask", oCHANGE_MASK, 12'h008);
    chk("lat_min_change", NC'(oCHANGE), 12'h001);
    hold(12'h008, 1);
    chk("pulse_end_mask", oCHANGE_MASK, 12'h000);
    chk("pulse_end_change", NC'(oCHANGE), 12'h000);

    // Worst-case latency: QUAL entry coincides with a tick that is not counted.
    step('0, 1'b1, 1'b0);
    hold(12'h000, 1);
    hold(12'h008, 14);
    chk("lat_max_before", oCASE, 12'h000);
    hold(12'h008, 1);
    chk("lat_max_case", oCASE, 12'h008);

    // Reset after two counted ticks aborts qualification; a full new one follows.
    step('0, 1'b1, 1'b0);
    hold(12'h080, 8);
    step(12'h080, 1'b1, 1'b0);
    chk("abort_case", oCASE, 12'h000);
    hold(12'h080, 11);
    chk("requal_before", oCASE, 12'h000);
    hold(12'h080, 1);
    chk("requal_case", oCASE, 12'h080);
    chk("requal_mask", oCHANGE_MASK, 12'h080);

`ifdef ROOM_DEBOUNCE_STICKY_EN
    step('0, 1'b1, 1'b0);
    hold(12'h004, 12);
    chk("sticky_set", oSTICKY, 12'h004);
    hold(12'h014, 11);
    chk("sticky_hold", oSTICKY, 12'h004);
    step(12'h014, 1'b0, 1'b1);
    chk("sticky_set_wins", oSTICKY, 12'h010);
    chk("sticky_case", oCASE, 12'h014);
`endif

    // Random traffic against the model.
    cur = '0;
    for (int b = 0; b < 150; b++) begin
      len  = $urandom_range(1, 24);
      flip = NC'($urandom) & NC'($urandom);
      cur  = cur ^ flip;
      for (int i = 0; i < len; i++)
        step(cur, ($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
